// File: rtl/tlb_v2_if.sv
// Signal bundle for the tlb_v2 translation buffer: two search ports, the
// invalidate handshake, the write/read entry ports and the refill pointer.
interface tlb_v2_if #(
  parameter int TLBNUM = 16
);
  localparam int IW = $clog2(TLBNUM);

  logic [18:0]   s0_vppn, s1_vppn;
  logic          s0_va_bit12, s1_va_bit12;
  logic [9:0]    s0_asid, s1_asid;
  logic          s0_found, s1_found;
  logic [IW-1:0] s0_index, s1_index;
  logic [19:0]   s0_ppn, s1_ppn;
  logic [5:0]    s0_ps, s1_ps;
  logic [1:0]    s0_plv, s1_plv, s0_mat, s1_mat;
  logic          s0_d, s1_d, s0_v, s1_v;

  logic          invtlb_valid, invtlb_ready, invtlb_done;
  logic [4:0]    invtlb_op;
  logic [9:0]    invtlb_asid;
  logic [18:0]   invtlb_vppn;

  logic          we, w_e, w_g, w_d0, w_d1, w_v0, w_v1;
  logic [IW-1:0] w_index;
  logic [18:0]   w_vppn;
  logic [5:0]    w_ps;
  logic [9:0]    w_asid;
  logic [19:0]   w_ppn0, w_ppn1;
  logic [1:0]    w_plv0, w_plv1, w_mat0, w_mat1;

  logic [IW-1:0] r_index;
  logic          r_e, r_g, r_d0, r_d1, r_v0, r_v1;
  logic [18:0]   r_vppn;
  logic [5:0]    r_ps;
  logic [9:0]    r_asid;
  logic [19:0]   r_ppn0, r_ppn1;
  logic [1:0]    r_plv0, r_plv1, r_mat0, r_mat1;

  logic [IW-1:0] fill_index;

  modport slave (
    input  s0_vppn, s1_vppn, s0_va_bit12, s1_va_bit12, s0_asid, s1_asid,
    output s0_found, s1_found, s0_index, s1_index, s0_ppn, s1_ppn, s0_ps, s1_ps,
           s0_plv, s1_plv, s0_mat, s1_mat, s0_d, s1_d, s0_v, s1_v,
    input  invtlb_valid, invtlb_op, invtlb_asid, invtlb_vppn,
    output invtlb_ready, invtlb_done,
    input  we, w_index, w_e, w_vppn, w_ps, w_asid, w_g, w_ppn0, w_ppn1,
           w_plv0, w_plv1, w_mat0, w_mat1, w_d0, w_d1, w_v0, w_v1,
    input  r_index,
    output r_e, r_vppn, r_ps, r_asid, r_g, r_ppn0, r_ppn1, r_plv0, r_plv1,
           r_mat0, r_mat1, r_d0, r_d1, r_v0, r_v1,
    output fill_index
  );

  modport master (
    output s0_vppn, s1_vppn, s0_va_bit12, s1_va_bit12, s0_asid, s1_asid,
    input  s0_found, s1_found, s0_index, s1_index, s0_ppn, s1_ppn, s0_ps, s1_ps,
           s0_plv, s1_plv, s0_mat, s1_mat, s0_d, s1_d, s0_v, s1_v,
    output invtlb_valid, invtlb_op, invtlb_asid, invtlb_vppn,
    input  invtlb_ready, invtlb_done,
    output we, w_index, w_e, w_vppn, w_ps, w_asid, w_g, w_ppn0, w_ppn1,
           w_plv0, w_plv1, w_mat0, w_mat1, w_d0, w_d1, w_v0, w_v1,
    output r_index,
    input  r_e, r_vppn, r_ps, r_asid, r_g, r_ppn0, r_ppn1, r_plv0, r_plv1,
           r_mat0, r_mat1, r_d0, r_d1, r_v0, r_v1,
    input  fill_index
  );
endinterface

// File: rtl/tlb_v2.sv
// Fully associative TLB with paired odd/even pages, two registered search ports,
// a lane-parallel invalidate sweep engine and a free-running refill pointer.
module tlb_v2 #(
  parameter int TLBNUM    = 16,
  parameter int INV_LANES = 4
) (
  input logic      clk,
  input logic      reset,
  tlb_v2_if.slave  bus
);
  localparam int IW = $clog2(TLBNUM);
  localparam logic [IW-1:0] LAST_PTR = IW'(TLBNUM - INV_LANES);
  localparam logic [IW-1:0] PTR_STEP = IW'(INV_LANES);

  typedef enum logic [1:0] {ST_IDLE, ST_SWEEP, ST_DONE} inv_state_t;

  logic          r_ent_e    [TLBNUM];
  logic [18:0]   r_ent_vppn [TLBNUM];
  logic          r_ent_4m   [TLBNUM];
  logic [9:0]    r_ent_asid [TLBNUM];
  logic          r_ent_g    [TLBNUM];
  logic [19:0]   r_ent_ppn0 [TLBNUM];
  logic [19:0]   r_ent_ppn1 [TLBNUM];
  logic [1:0]    r_ent_plv0 [TLBNUM];
  logic [1:0]    r_ent_plv1 [TLBNUM];
  logic [1:0]    r_ent_mat0 [TLBNUM];
  logic [1:0]    r_ent_mat1 [TLBNUM];
  logic          r_ent_d0   [TLBNUM];
  logic          r_ent_d1   [TLBNUM];
  logic          r_ent_v0   [TLBNUM];
  logic          r_ent_v1   [TLBNUM];

  // A 4MB entry ignores the low ten VPPN bits.
  function automatic logic vppn_eq(input logic [18:0] a, input logic [18:0] b,
                                   input logic big);
    return (a[18:10] == b[18:10]) && (big || (a[9:0] == b[9:0]));
  endfunction

  function automatic logic inv_hit(input logic [4:0] op, input logic g,
                                   input logic am, input logic vm);
    case (op)
      5'd0, 5'd1: return 1'b1;
      5'd2:       return g;
      5'd3:       return !g;
      5'd4:       return !g && am;
      5'd5:       return !g && am && vm;
      5'd6:       return (g || am) && vm;
      default:    return 1'b0;
    endcase
  endfunction

  logic [18:0]       w_q_vppn  [2];
  logic              w_q_bit12 [2];
  logic [9:0]        w_q_asid  [2];
  logic [TLBNUM-1:0] w_hit_vec [2];
  logic              w_hit     [2];
  logic [IW-1:0]     w_hit_idx [2];
  logic              w_odd     [2];
  logic [19:0]       w_sel_ppn [2];
  logic [5:0]        w_sel_ps  [2];
  logic [1:0]        w_sel_plv [2];
  logic [1:0]        w_sel_mat [2];
  logic              w_sel_d   [2];
  logic              w_sel_v   [2];

  assign w_q_vppn[0]  = bus.s0_vppn;
  assign w_q_vppn[1]  = bus.s1_vppn;
  assign w_q_bit12[0] = bus.s0_va_bit12;
  assign w_q_bit12[1] = bus.s1_va_bit12;
  assign w_q_asid[0]  = bus.s0_asid;
  assign w_q_asid[1]  = bus.s1_asid;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_hit_vec[p] = '0;
      w_hit[p]     = 1'b0;
      w_hit_idx[p] = '0;
      w_odd[p]     = 1'b0;
      w_sel_ppn[p] = '0;
      w_sel_ps[p]  = '0;
      w_sel_plv[p] = '0;
      w_sel_mat[p] = '0;
      w_sel_d[p]   = 1'b0;
      w_sel_v[p]   = 1'b0;
      for (int i = 0; i < TLBNUM; i++)
        w_hit_vec[p][i] = r_ent_e[i] && vppn_eq(r_ent_vppn[i], w_q_vppn[p], r_ent_4m[i])
                          && (r_ent_g[i] || (r_ent_asid[i] == w_q_asid[p]));
      // Descending scan so the lowest matching index is the one kept.
      for (int i = TLBNUM - 1; i >= 0; i--)
        if (w_hit_vec[p][i]) begin
          w_hit[p]     = 1'b1;
          w_hit_idx[p] = IW'(i);
        end
      if (w_hit[p]) begin
        w_odd[p]     = r_ent_4m[w_hit_idx[p]] ? w_q_vppn[p][9] : w_q_bit12[p];
        w_sel_ps[p]  = r_ent_4m[w_hit_idx[p]] ? 6'd22 : 6'd12;
        w_sel_ppn[p] = w_odd[p] ? r_ent_ppn1[w_hit_idx[p]] : r_ent_ppn0[w_hit_idx[p]];
        w_sel_plv[p] = w_odd[p] ? r_ent_plv1[w_hit_idx[p]] : r_ent_plv0[w_hit_idx[p]];
        w_sel_mat[p] = w_odd[p] ? r_ent_mat1[w_hit_idx[p]] : r_ent_mat0[w_hit_idx[p]];
        w_sel_d[p]   = w_odd[p] ? r_ent_d1[w_hit_idx[p]]   : r_ent_d0[w_hit_idx[p]];
        w_sel_v[p]   = w_odd[p] ? r_ent_v1[w_hit_idx[p]]   : r_ent_v0[w_hit_idx[p]];
      end
    end
  end

  logic          r_s_found [2];
  logic [IW-1:0] r_s_index [2];
  logic [19:0]   r_s_ppn   [2];
  logic [5:0]    r_s_ps    [2];
  logic [1:0]    r_s_plv   [2];
  logic [1:0]    r_s_mat   [2];
  logic          r_s_d     [2];
  logic          r_s_v     [2];

  // Search result register stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int p = 0; p < 2; p++) begin
        r_s_found[p] <= 1'b0;
        r_s_index[p] <= '0;
        r_s_ppn[p]   <= '0;
        r_s_ps[p]    <= '0;
        r_s_plv[p]   <= '0;
        r_s_mat[p]   <= '0;
        r_s_d[p]     <= 1'b0;
        r_s_v[p]     <= 1'b0;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        r_s_found[p] <= w_hit[p];
        r_s_index[p] <= w_hit_idx[p];
        r_s_ppn[p]   <= w_sel_ppn[p];
        r_s_ps[p]    <= w_sel_ps[p];
        r_s_plv[p]   <= w_sel_plv[p];
        r_s_mat[p]   <= w_sel_mat[p];
        r_s_d[p]     <= w_sel_d[p];
        r_s_v[p]     <= w_sel_v[p];
      end
    end
  end

  assign bus.s0_found = r_s_found[0];
  assign bus.s1_found = r_s_found[1];
  assign bus.s0_index = r_s_index[0];
  assign bus.s1_index = r_s_index[1];
  assign bus.s0_ppn   = r_s_ppn[0];
  assign bus.s1_ppn   = r_s_ppn[1];
  assign bus.s0_ps    = r_s_ps[0];
  assign bus.s1_ps    = r_s_ps[1];
  assign bus.s0_plv   = r_s_plv[0];
  assign bus.s1_plv   = r_s_plv[1];
  assign bus.s0_mat   = r_s_mat[0];
  assign bus.s1_mat   = r_s_mat[1];
  assign bus.s0_d     = r_s_d[0];
  assign bus.s1_d     = r_s_d[1];
  assign bus.s0_v     = r_s_v[0];
  assign bus.s1_v     = r_s_v[1];

  inv_state_t        r_state, w_state_nxt;
  logic [IW-1:0]     r_ptr;
  logic [4:0]        r_inv_op;
  logic [9:0]        r_inv_asid;
  logic [18:0]       r_inv_vppn;
  logic              w_accept, w_ready, w_done;
  logic [TLBNUM-1:0] w_clr;

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_done      = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_ready = 1'b1;
        if (bus.invtlb_valid) begin
          if (bus.invtlb_op <= 5'd6) begin
            w_accept    = 1'b1;
            w_state_nxt = ST_SWEEP;
          end else begin
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_SWEEP: if (r_ptr == LAST_PTR) w_state_nxt = ST_DONE;
      ST_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept)                r_ptr <= '0;
      else if (r_state == ST_SWEEP) r_ptr <= r_ptr + PTR_STEP;
    end
  end

  // Request operands are only consumed during SWEEP, which reset always exits.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_inv_op   <= bus.invtlb_op;
      r_inv_asid <= bus.invtlb_asid;
      r_inv_vppn <= bus.invtlb_vppn;
    end
  end

  always_comb begin
    w_clr = '0;
    for (int i = 0; i < TLBNUM; i++)
      if ((r_state == ST_SWEEP) && ((i / INV_LANES) == (int'(r_ptr) / INV_LANES)))
        w_clr[i] = inv_hit(r_inv_op, r_ent_g[i], r_ent_asid[i] == r_inv_asid,
                           vppn_eq(r_ent_vppn[i], r_inv_vppn, r_ent_4m[i]));
  end

  assign bus.invtlb_ready = w_ready;
  assign bus.invtlb_done  = w_done;

  // A write to an entry takes priority over a sweep clear of that entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < TLBNUM; i++) begin
        r_ent_e[i]    <= 1'b0;
        r_ent_vppn[i] <= '0;
        r_ent_4m[i]   <= 1'b0;
        r_ent_asid[i] <= '0;
        r_ent_g[i]    <= 1'b0;
        r_ent_ppn0[i] <= '0;
        r_ent_ppn1[i] <= '0;
        r_ent_plv0[i] <= '0;
        r_ent_plv1[i] <= '0;
        r_ent_mat0[i] <= '0;
        r_ent_mat1[i] <= '0;
        r_ent_d0[i]   <= 1'b0;
        r_ent_d1[i]   <= 1'b0;
        r_ent_v0[i]   <= 1'b0;
        r_ent_v1[i]   <= 1'b0;
      end
    end else begin
      for (int i = 0; i < TLBNUM; i++) begin
        if (bus.we && (bus.w_index == IW'(i))) begin
          r_ent_e[i]    <= bus.w_e;
          r_ent_vppn[i] <= bus.w_vppn;
          r_ent_4m[i]   <= (bus.w_ps == 6'd22);
          r_ent_asid[i] <= bus.w_asid;
          r_ent_g[i]    <= bus.w_g;
          r_ent_ppn0[i] <= bus.w_ppn0;
          r_ent_ppn1[i] <= bus.w_ppn1;
          r_ent_plv0[i] <= bus.w_plv0;
          r_ent_plv1[i] <= bus.w_plv1;
          r_ent_mat0[i] <= bus.w_mat0;
          r_ent_mat1[i] <= bus.w_mat1;
          r_ent_d0[i]   <= bus.w_d0;
          r_ent_d1[i]   <= bus.w_d1;
          r_ent_v0[i]   <= bus.w_v0;
          r_ent_v1[i]   <= bus.w_v1;
        end else if (w_clr[i]) begin
          r_ent_e[i] <= 1'b0;
        end
      end
    end
  end

  assign bus.r_e    = r_ent_e[bus.r_index];
  assign bus.r_vppn = r_ent_vppn[bus.r_index];
  assign bus.r_ps   = r_ent_4m[bus.r_index] ? 6'd22 : 6'd12;
  assign bus.r_asid = r_ent_asid[bus.r_index];
  assign bus.r_g    = r_ent_g[bus.r_index];
  assign bus.r_ppn0 = r_ent_ppn0[bus.r_index];
  assign bus.r_ppn1 = r_ent_ppn1[bus.r_index];
  assign bus.r_plv0 = r_ent_plv0[bus.r_index];
  assign bus.r_plv1 = r_ent_plv1[bus.r_index];
  assign bus.r_mat0 = r_ent_mat0[bus.r_index];
  assign bus.r_mat1 = r_ent_mat1[bus.r_index];
  assign bus.r_d0   = r_ent_d0[bus.r_index];
  assign bus.r_d1   = r_ent_d1[bus.r_index];
  assign bus.r_v0   = r_ent_v0[bus.r_index];
  assign bus.r_v1   = r_ent_v1[bus.r_index];

  logic [IW-1:0] r_fill;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_fill <= '0;
    else       r_fill <= r_fill + IW'(1);
  end

  assign bus.fill_index = r_fill;
endmodule

// File: doc/tlb_v2.md
TLB_V2 -- requirements
Module: tlb_v2

Interface
REQ-001 SHALL have parameter TLBNUM, default 16: entry count, power of 2, range 4..64.
REQ-002 SHALL have parameter INV_LANES, default 4: entries examined per invalidate-sweep cycle, power of 2, divides TLBNUM.
REQ-003 SHALL have port clk, in, 1: single clock, all state updates on the rising edge.
REQ-004 SHALL have port reset, in, 1: asynchronous, active-high reset.
REQ-005 SHALL have ports s0_vppn/s1_vppn, in, 19: search VPPN, port 0 for fetch, port 1 for load/store.
REQ-006 SHALL have ports s0_va_bit12/s1_va_bit12, in, 1: odd/even page select for 4KB pages.
REQ-007 SHALL have ports s0_asid/s1_asid, in, 10: search ASID.
REQ-008 SHALL have registered search outputs per port x in {0,1}: sx_found (1), sx_index (clog2(TLBNUM)), sx_ppn (20), sx_ps (6), sx_plv (2), sx_mat (2), sx_d (1), sx_v (1).
REQ-009 SHALL have invalidate request inputs: invtlb_valid (1), invtlb_op (5), invtlb_asid (10), invtlb_vppn (19).
REQ-010 SHALL have invtlb_ready, out, 1: engine idle; and invtlb_done, out, 1: one-cycle completion pulse.
REQ-011 SHALL have write port inputs: we (1), w_index (clog2(TLBNUM)), w_e (1), w_vppn (19), w_ps (6), w_asid (10), w_g (1), w_ppn0/w_ppn1 (20), w_plv0/w_plv1 (2), w_mat0/w_mat1 (2), w_d0/w_d1 (1), w_v0/w_v1 (1).
REQ-012 SHALL have read port: r_index in (clog2(TLBNUM)), with r_* outputs mirroring every w_* field.
REQ-013 SHALL have fill_index, out, clog2(TLBNUM): round-robin refill pointer.

Function
REQ-014 SHALL store the page size as a single 4MB flag: set when w_ps==22, otherwise 4KB; r_ps and sx_ps return 22 or 12.
REQ-015 SHALL define an entry match as: e=1, vppn[18:10] equal, (4MB or vppn[9:0] equal), and (g=1 or asid equal).
REQ-016 SHALL select the page by va_bit12 for 4KB entries and by vppn[9] for 4MB entries; 1 selects the odd page (ppn1/plv1/mat1/d1/v1).
REQ-017 SHALL report the lowest matching index when several entries match.
REQ-018 SHALL register search results with 1-cycle latency: outputs after edge N reflect inputs and array contents before edge N.
REQ-019 SHALL drive found=0 and all other sx_* outputs to 0 on a miss.
REQ-020 SHALL write all fields of entry w_index at the edge when we=1; a same-cycle search sees the old contents.
REQ-021 SHALL make the read port combinational, reflecting the array as of the last edge.
REQ-022 SHALL implement the invalidate FSM with states IDLE, SWEEP, DONE; invtlb_ready=1 only in IDLE.
REQ-023 SHALL, in IDLE with invtlb_valid=1 and op<=6: latch op/asid/vppn, set ptr=0, go to SWEEP.
REQ-024 SHALL, in IDLE with invtlb_valid=1 and op>6: go to DONE with no entry change.
REQ-025 SHALL, in SWEEP, each cycle clear e on entries ptr..ptr+INV_LANES-1 whose mask bit is set, then advance ptr by INV_LANES; after the last group, go to DONE.
REQ-026 SHALL use these masks, with the vppn match per REQ-015 using the entry's page size: op0/1 all; op2 g=1; op3 g=0; op4 g=0 & asid; op5 g=0 & asid & vppn; op6 (g=1 | asid) & vppn.
REQ-027 SHALL, in DONE, assert invtlb_done for one cycle, then return to IDLE; invtlb_valid is ignored outside IDLE.
REQ-028 SHALL let a write win over a sweep clear on the same entry in the same cycle (e takes w_e); searches during a sweep see partially swept state.
REQ-029 SHALL increment fill_index every cycle, wrapping from TLBNUM-1 to 0.

Reset
REQ-030 SHALL, on reset assertion, immediately clear all entry fields (including e) to 0, all sx_* outputs to 0, fill_index to 0, and invtlb_done to 0, and force the FSM to IDLE (invtlb_ready=1).
REQ-031 SHALL abort an in-progress sweep on reset with no invtlb_done pulse.

Verification
REQ-032 SHALL cover: write idx3 {vppn=0x12345, ps=12, asid=5, g=0, ppn0=0xAAAAA, ppn1=0xBBBBB, v0=v1=1}; s0 search 0x12345/asid5/bit12=1 -> next cycle found=1, index=3, ppn=0xBBBBB; asid=6 -> found=0.
REQ-033 SHALL cover: idx7 4MB {vppn=0x12C00, ps=22, g=1}; s1 search vppn=0x12FFF with any asid -> found=1, index=7, odd page, ps=22.
REQ-034 SHALL cover: identical entries at idx2 and idx9 -> index=2.
REQ-035 SHALL cover: with TLBNUM=16 and INV_LANES=4, op5 asid=5 vppn=0x12345 accepted -> ready=0 for 4 SWEEP cycles plus DONE, invtlb_done pulses once; idx3 e=0; idx7 (g=1) remains e=1.
REQ-036 SHALL cover: op=9 -> invtlb_done on the next cycle, no entry change.
REQ-037 SHALL cover: op0 sweep while writing idx0 w_e=1 in the clearing cycle -> idx0 e=1 afterwards.
REQ-038 SHALL cover: reset asserted mid-sweep -> ready=1 immediately, no done pulse, all e=0.
